mgmt_fan_monitor: RTL and testbench

Parametrised N-channel fan tachometer and health monitor for the management subsystem. It replaces the fixed pair of per-fan tachometer instances with one block. Each channel measures RPM over a configurable gate window, with glitch filtering, stall detection, per-channel minimum-RPM alarms and a level IRQ. Inputs come from the fan_tach pins; outputs feed the management register interface.

---
 rtl/mgmt_fan_monitor_pkg.sv | 21 ++
 rtl/mgmt_fan_monitor_channel.sv | 85 ++++++++
 rtl/mgmt_fan_monitor.sv | 106 ++++++++++
 tb/tb_mgmt_fan_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_fan_monitor_pkg.sv
// Shared types, constants and the RPM scaling helper for the fan monitor.
package mgmt_fan_monitor_pkg;

   typedef logic [15:0] rpm_t;
   typedef logic [15:0] edge_cnt_t;

   localparam rpm_t      RPM_MAX      = 16'hFFFF;
   localparam edge_cnt_t EDGE_CNT_MAX = 16'hFFFF;

   // edges * (60 / ppr) evaluated in 32 bits, clamped to the 16-bit RPM range.
   function automatic rpm_t rpm_scale(input edge_cnt_t edges, input int unsigned ppr);
      logic [31:0] prod;
      prod = {16'd0, edges} * (32'd60 / 32'(ppr));
      if (prod > {16'd0, RPM_MAX}) begin
         return RPM_MAX;
      end else begin
         return prod[15:0];
      end
   endfunction

endpackage

// File: rtl/mgmt_fan_monitor_channel.sv
// One tach channel: 2-flop synchroniser, glitch filter, rising-edge counter
// and the edge count latched at the end of each gate window.
module mgmt_fan_channel
   import mgmt_fan_monitor_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tach,
   input  logic      win_end,
   output edge_cnt_t edges
);

   logic      sync0_q, sync0_d;
   logic      sync1_q, sync1_d;
   logic      filt_q, filt_d;
   logic      filt_prev_q, filt_prev_d;
   logic [7:0] stable_q, stable_d;
   edge_cnt_t edge_cnt_q, edge_cnt_d;
   edge_cnt_t latched_q, latched_d;

   logic       rise_s;
   logic [8:0] stable_inc_s;

   assign rise_s       = filt_q & ~filt_prev_q;
   assign stable_inc_s = {1'b0, stable_q} + 9'd1;

   // Next-state: synchroniser, filter, edge counter and window latch.
   always_comb begin
      sync0_d     = tach;
      sync1_d     = sync0_q;
      filt_d      = filt_q;
      filt_prev_d = filt_q;
      stable_d    = 8'd0;
      edge_cnt_d  = edge_cnt_q;
      latched_d   = latched_q;

      // The level only follows the input after FILTER_LEN consecutive disagreeing samples.
      if (sync1_q != filt_q) begin
         if (stable_inc_s == 9'(FILTER_LEN)) begin
            filt_d   = ~filt_q;
            stable_d = 8'd0;
         end else begin
            stable_d = stable_inc_s[7:0];
         end
      end else begin
         stable_d = 8'd0;
      end

      // An edge seen on the terminal cycle belongs to the window that is starting.
      if (win_end) begin
         latched_d  = edge_cnt_q;
         edge_cnt_d = {15'd0, rise_s};
      end else if (rise_s && (edge_cnt_q != EDGE_CNT_MAX)) begin
         edge_cnt_d = edge_cnt_q + 16'd1;
      end else begin
         edge_cnt_d = edge_cnt_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q     <= 1'b0;
         sync1_q     <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         stable_q    <= 8'd0;
         edge_cnt_q  <= 16'd0;
         latched_q   <= 16'd0;
      end else begin
         sync0_q     <= sync0_d;
         sync1_q     <= sync1_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         stable_q    <= stable_d;
         edge_cnt_q  <= edge_cnt_d;
         latched_q   <= latched_d;
      end
   end

   assign edges = latched_q;

endmodule

// File: rtl/mgmt_fan_monitor.sv
// N-channel fan tachometer and health monitor: shared gate window, RPM
// scaling, stall detection, sticky low-speed alarms and a level IRQ.
module mgmt_fan_monitor
   import mgmt_fan_monitor_pkg::*;
#(
   parameter int unsigned NUM_FANS       = 2,
   parameter int unsigned WINDOW_CYCLES  = 250000000,
   parameter int unsigned PULSES_PER_REV = 2,
   parameter int unsigned FILTER_LEN     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_FANS-1:0]    tach,
   input  logic [16*NUM_FANS-1:0] min_rpm,
   input  logic [NUM_FANS-1:0]    alarm_clear,
   output logic [16*NUM_FANS-1:0] rpm,
   output logic                   update,
   output logic [NUM_FANS-1:0]    stall,
   output logic [NUM_FANS-1:0]    alarm,
   output logic                   irq
);

   localparam int unsigned      WIN_W    = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
   logic                   pub_q, pub_d;
   logic                   update_q, update_d;
   logic [16*NUM_FANS-1:0] rpm_q, rpm_d;
   logic [NUM_FANS-1:0]    stall_q, stall_d;
   logic [NUM_FANS-1:0]    alarm_q, alarm_d;
   logic                   irq_q, irq_d;

   logic                   win_end_s;
   edge_cnt_t              lat_s    [NUM_FANS];
   rpm_t                   scaled_s [NUM_FANS];
   logic [NUM_FANS-1:0]    alarm_set_s;

   assign win_end_s = (win_cnt_q == WIN_LAST);

   for (genvar i = 0; i < NUM_FANS; i++) begin : g_chan
      mgmt_fan_channel #(
         .FILTER_LEN (FILTER_LEN)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .tach    (tach[i]),
         .win_end (win_end_s),
         .edges   (lat_s[i])
      );

      assign scaled_s[i]    = rpm_scale(lat_s[i], PULSES_PER_REV);
      // A stall scales to 0 RPM, so any nonzero threshold trips on it.
      assign alarm_set_s[i] = pub_q && (min_rpm[16*i+15:16*i] != 16'd0) &&
                              (scaled_s[i] < min_rpm[16*i+15:16*i]);
   end

   // Next-state: window counter, publish stage, alarm and irq.
   always_comb begin
      win_cnt_d = win_end_s ? {WIN_W{1'b0}} : (win_cnt_q + WIN_W'(1));
      pub_d     = win_end_s;
      update_d  = pub_q;
      rpm_d     = rpm_q;
      stall_d   = stall_q;
      alarm_d   = alarm_set_s | (alarm_q & ~alarm_clear);
      irq_d     = |alarm_q;

      if (pub_q) begin
         for (int unsigned i = 0; i < NUM_FANS; i++) begin
            rpm_d[16*i +: 16] = scaled_s[i];
            stall_d[i]        = (lat_s[i] == 16'd0);
         end
      end else begin
         rpm_d   = rpm_q;
         stall_d = stall_q;
      end
   end

   // Output and control registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q <= {WIN_W{1'b0}};
         pub_q     <= 1'b0;
         update_q  <= 1'b0;
         rpm_q     <= {(16*NUM_FANS){1'b0}};
         stall_q   <= {NUM_FANS{1'b0}};
         alarm_q   <= {NUM_FANS{1'b0}};
         irq_q     <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         pub_q     <= pub_d;
         update_q  <= update_d;
         rpm_q     <= rpm_d;
         stall_q   <= stall_d;
         alarm_q   <= alarm_d;
         irq_q     <= irq_d;
      end
   end

   assign rpm    = rpm_q;
   assign update = update_q;
   assign stall  = stall_q;
   assign alarm  = alarm_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_mgmt_fan_monitor.sv
// Bench for mgmt_fan_monitor: pin-level behavioural model checked every cycle,
// plus hand-computed expectations at the scenario milestones.
module tb_mgmt_fan_monitor;

   localparam int NF = 2;
   localparam int W  = 1000;
   localparam int L  = 4;
   localparam int P  = 2;
   localparam int SW = 5000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NF-1:0]     tach;
   logic [16*NF-1:0]  min_rpm;
   logic [NF-1:0]     alarm_clear;
   logic [16*NF-1:0]  rpm;
   logic              update;
   logic [NF-1:0]     stall;
   logic [NF-1:0]     alarm;
   logic              irq;

   logic              sat_rst_n;
   logic              sat_tach;
   logic [15:0]       sat_rpm;
   logic              sat_update;
   logic              sat_stall;
   logic              sat_alarm;
   logic              sat_irq;
   logic              sat_done;

   mgmt_fan_monitor #(
      .NUM_FANS(NF), .WINDOW_CYCLES(W), .PULSES_PER_REV(P), .FILTER_LEN(L)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tach(tach), .min_rpm(min_rpm),
      .alarm_clear(alarm_clear), .rpm(rpm), .update(update),
      .stall(stall), .alarm(alarm), .irq(irq)
   );

   // 4-cycle tach period, 1-cycle filter, 1 pulse/rev: ~1249 edges * 60 saturates.
   mgmt_fan_monitor #(
      .NUM_FANS(1), .WINDOW_CYCLES(SW), .PULSES_PER_REV(1), .FILTER_LEN(1)
   ) sat_dut (
      .clk(clk), .rst_n(sat_rst_n), .tach(sat_tach), .min_rpm(16'd0),
      .alarm_clear(1'b0), .rpm(sat_rpm), .update(sat_update),
      .stall(sat_stall), .alarm(sat_alarm), .irq(sat_irq)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- tach drivers: 0 = low, 1 = 100-cycle square, 2 = 2-cycle glitch / 50
   int mode [NF];
   int drv_cyc = 0;

   initial begin
      forever begin
         @(negedge clk);
         drv_cyc++;
         for (int c = 0; c < NF; c++) begin
            case (mode[c])
               1:       tach[c] = ((drv_cyc % 100) < 50);
               2:       tach[c] = ((drv_cyc % 50) < 2);
               default: tach[c] = 1'b0;
            endcase
         end
         sat_tach = ((drv_cyc % 4) < 2);
      end
   end

   // ---------------- behavioural model (cycle p = p-th rising edge since reset release)
   int          p;
   int          m_lvl [NF];
   int          m_run [NF];
   int          m_due [NF][$];
   int          m_win [NF];
   int          m_lat [NF];
   int          pub_due;
   int          m_rpm [NF];
   bit [NF-1:0] m_stall, m_alarm;
   bit          m_update, m_irq;

   task automatic model_reset();
      p = 0;
      pub_due = -1;
      m_stall = '0; m_alarm = '0; m_update = 1'b0; m_irq = 1'b0;
      for (int c = 0; c < NF; c++) begin
         m_lvl[c] = 0; m_run[c] = 0; m_win[c] = 0; m_lat[c] = 0; m_rpm[c] = 0;
         m_due[c].delete();
      end
   endtask

   task automatic model_step();
      bit irq_next;
      int r;
      int thr;
      bit set;
      p++;
      irq_next = |m_alarm;
      // A window closes every W edges; its figures appear one edge later.
      if (p % W == 0) pub_due = p + 1;
      m_update = (p == pub_due);
      for (int c = 0; c < NF; c++) begin
         // L consecutive samples disagreeing with the level flip it; a rise is counted 3 edges later.
         if (int'(tach[c]) != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == L) begin
               m_lvl[c] = int'(tach[c]);
               m_run[c] = 0;
               if (m_lvl[c] == 1) m_due[c].push_back(p + 3);
            end
         end else begin
            m_run[c] = 0;
         end
         if (p % W == 0) begin
            m_lat[c] = m_win[c];
            m_win[c] = 0;
         end
         while (m_due[c].size() > 0 && m_due[c][0] == p) begin
            void'(m_due[c].pop_front());
            if (m_win[c] < 65535) m_win[c]++;
         end
         set = 1'b0;
         if (m_update) begin
            r = m_lat[c] * (60 / P);
            if (r > 65535) r = 65535;
            m_rpm[c]   = r;
            m_stall[c] = (m_lat[c] == 0);
            thr = int'(min_rpm[16*c +: 16]);
            set = (thr != 0) && (r < thr);
         end
         m_alarm[c] = set || (m_alarm[c] && !alarm_clear[c]);
      end
      m_irq = irq_next;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst_n !== 1'b1) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle comparison against the model
   logic [31:0] exp_rpm;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && p > 0) begin
            exp_rpm = '0;
            for (int c = 0; c < NF; c++) exp_rpm[16*c +: 16] = 16'(m_rpm[c]);
            check("model_rpm",    rpm,    exp_rpm);
            check("model_stall",  32'(stall),  32'(m_stall));
            check("model_alarm",  32'(alarm),  32'(m_alarm));
            check("model_update", 32'(update), 32'(m_update));
            check("model_irq",    32'(irq),    32'(m_irq));
         end
      end
   end

   // Bounded wait until the negedge following rising edge number 'target'.
   task automatic wait_p(input int target);
      int guard;
      guard = 0;
      while (p < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (p != target) begin
         tests++;
         fails++;
         $display("FAIL wait_p: reached %0d required %0d", p, target);
      end
   endtask

   // ---------------- saturation channel
   initial begin
      int n;
      sat_done = 1'b0;
      n = 0;
      @(posedge sat_rst_n);
      while (sat_update !== 1'b1 && n < SW + 100) begin
         @(negedge clk);
         n++;
      end
      check("sat_first_update", n, SW + 1);
      check("sat_rpm", 32'(sat_rpm), 32'h0000FFFF);
      check("sat_stall", 32'(sat_stall), 32'd0);
      sat_done = 1'b1;
   end

   // ---------------- directed scenario
   initial begin
      int upd;
      int n;
      rst_n = 1'b0; sat_rst_n = 1'b0;
      tach = '0; sat_tach = 1'b0; min_rpm = '0; alarm_clear = '0;
      mode[0] = 1; mode[1] = 2;
      repeat (3) @(negedge clk);
      check("reset_rpm",    rpm, 32'd0);
      check("reset_update", 32'(update), 32'd0);
      check("reset_stall",  32'(stall), 32'd0);
      check("reset_alarm",  32'(alarm), 32'd0);
      check("reset_irq",    32'(irq), 32'd0);
      rst_n = 1'b1; sat_rst_n = 1'b1;

      // Steady square on ch0, glitches on ch1: window 1 (edges 1000..1999) holds 10 rises.
      wait_p(1001);
      check("first_update", 32'(update), 32'd1);
      wait_p(2001);
      check("steady_rpm0", 32'(rpm[15:0]), 32'd300);
      check("glitch_rpm1", 32'(rpm[31:16]), 32'd0);
      check("steady_stall", 32'(stall), 32'b10);
      check("steady_alarm", 32'(alarm), 32'd0);
      upd = 0;
      for (int k = 0; k < 1000; k++) begin
         if (update === 1'b1) upd++;
         @(negedge clk);
      end
      check("update_per_window", upd, 32'd1);

      // Reset halfway through a window.
      wait_p(3500);
      rst_n = 1'b0;
      #1;
      check("midreset_rpm",    rpm, 32'd0);
      check("midreset_stall",  32'(stall), 32'd0);
      check("midreset_update", 32'(update), 32'd0);
      check("midreset_alarm",  32'(alarm), 32'd0);
      check("midreset_irq",    32'(irq), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (update !== 1'b1 && n < W + 100) begin
         @(negedge clk);
         n++;
      end
      check("post_reset_first_update", n, W + 1);

      // Both fans stop; ch0 alarms at 100 RPM, ch1 alarm disabled.
      wait_p(1500);
      mode[0] = 0; mode[1] = 0;
      min_rpm = {16'd0, 16'd100};
      wait_p(2001);
      check("partial_window_no_alarm", 32'(alarm), 32'd0);
      wait_p(3001);
      check("stall_both", 32'(stall), 32'b11);
      check("stall_alarm", 32'(alarm), 32'b01);
      check("irq_lags_alarm", 32'(irq), 32'd0);
      wait_p(3002);
      check("stall_irq", 32'(irq), 32'd1);

      // Clear mid-window while the fault persists.
      wait_p(3500);
      alarm_clear = 2'b01;
      @(negedge clk);
      alarm_clear = 2'b00;
      wait_p(3502);
      check("cleared_alarm", 32'(alarm), 32'd0);
      check("cleared_irq", 32'(irq), 32'd0);
      wait_p(4001);
      check("reset_alarm_after_clear", 32'(alarm), 32'b01);
      wait_p(4002);
      check("reset_irq_after_clear", 32'(irq), 32'd1);

      // Clear landing on the publish cycle loses to the set.
      wait_p(5000);
      alarm_clear = 2'b01;
      @(negedge clk);
      alarm_clear = 2'b00;
      check("set_beats_clear", 32'(alarm), 32'b01);
      wait_p(5002);
      check("set_beats_clear_irq", 32'(irq), 32'd1);

      n = 0;
      while (sat_done !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("sat_finished", 32'(sat_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
